// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin
// arbiter that owns the 4:1 mux select.
package mux4_rr_arbiter_pkg;

    localparam int N_REQ = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Search order last+1, last+2, last+3, last; the lowest offset wins.
    function automatic logic [1:0] pick(
        input logic [N_REQ-1:0] r,
        input logic [1:0]       last
    );
        logic [1:0] idx;
        pick = last;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = last + 2'(i);
            if (r[idx]) pick = idx;
        end
    endfunction

    function automatic logic [N_REQ-1:0] onehot(
        input logic [1:0] idx
    );
        onehot = N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester-side bundle of the arbiter:
// requests and data in, grant and muxed data out.
interface mux4_rr_arbiter_if;
    import mux4_rr_arbiter_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] din;
    logic [N_REQ-1:0] gnt;
    logic [1:0]       sel;
    logic             dout;
    logic             dout_vld;
    logic             busy;
    logic             timeout;

    modport master (
        output req, din,
        input  gnt, sel, dout, dout_vld, busy, timeout
    );

    modport slave (
        input  req, din,
        output gnt, sel, dout, dout_vld, busy, timeout
    );

endinterface

// File: rtl/mux4_rr_arbiter_mux.sv
// Structural 4:1 bit mux built as a tree
// of 2:1 case muxes.
module mux4_rr_arbiter_mux (
    input  logic [3:0] d,
    input  logic [1:0] s,
    output logic       y
);

    logic lo;
    logic hi;

    mux2to1_case u_lo (
        .a (d[0]),
        .b (d[1]),
        .s (s[0]),
        .y (lo)
    );

    mux2to1_case u_hi (
        .a (d[2]),
        .b (d[3]),
        .s (s[0]),
        .y (hi)
    );

    mux2to1_case u_out (
        .a (lo),
        .b (hi),
        .s (s[1]),
        .y (y)
    );

endmodule

module mux2to1_case (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);

    always_comb begin
        y = a;
        case (s)
            1'b0:    y = a;
            1'b1:    y = b;
            default: y = a;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter with bounded hold time and
// a one-cycle release gap, driving a shared 4:1 mux.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    mux4_rr_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_HOLD);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       last;
    logic [1:0]       nxt;
    logic [N_REQ-1:0] gnt_q;
    logic [1:0]       sel_q;
    logic             vld_q;
    logic             busy_q;
    logic             to_q;
    logic             mux_y;

    assign nxt = pick(bus.req, last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            last   <= 2'd3;
            gnt_q  <= '0;
            sel_q  <= 2'd0;
            vld_q  <= 1'b0;
            busy_q <= 1'b0;
            to_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE, RELEASE: begin
                    to_q <= 1'b0;
                    if (|bus.req) begin
                        state  <= GRANT;
                        gnt_q  <= onehot(nxt);
                        sel_q  <= nxt;
                        last   <= nxt;
                        cnt    <= CNT_W'(1);
                        vld_q  <= 1'b1;
                        busy_q <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                GRANT: begin
                    // A still-asserted request here means the hold limit hit.
                    if (!bus.req[sel_q] || cnt == MAX_CNT) begin
                        state <= RELEASE;
                        gnt_q <= '0;
                        vld_q <= 1'b0;
                        to_q  <= bus.req[sel_q];
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    gnt_q  <= '0;
                    vld_q  <= 1'b0;
                    busy_q <= 1'b0;
                    to_q   <= 1'b0;
                end
            endcase
        end
    end

    mux4_rr_arbiter_mux mux4to1_inst (
        .d (bus.din),
        .s (sel_q),
        .y (mux_y)
    );

    assign bus.gnt      = gnt_q;
    assign bus.sel      = sel_q;
    assign bus.dout_vld = vld_q;
    assign bus.busy     = busy_q;
    assign bus.timeout  = to_q;
    assign bus.dout     = mux_y & vld_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: vector table
// plus hand sequences for hold period and async reset.
module tb_mux4_rr_arbiter;

    logic clk;
    logic rst;

    mux4_rr_arbiter_if bus ();
    mux4_rr_arbiter_if bus1 ();

    mux4_rr_arbiter #(.MAX_HOLD(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mux4_rr_arbiter #(.MAX_HOLD(1), .CNT_W(8)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    assign bus1.req = bus.req;
    assign bus1.din = bus.din;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] din;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       dout;
        logic       vld;
        logic       busy;
        logic       to;
    } vec_t;

    localparam int NV = 25;
    vec_t v [NV];

    int n_chk;
    int n_fail;

    task automatic chk(
        input string      name,
        input logic [7:0] act,
        input logic [7:0] exp
    );
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t e);
        chk({tag, ".gnt"},  8'(bus.gnt),      8'(e.gnt));
        chk({tag, ".sel"},  8'(bus.sel),      8'(e.sel));
        chk({tag, ".dout"}, 8'(bus.dout),     8'(e.dout));
        chk({tag, ".vld"},  8'(bus.dout_vld), 8'(e.vld));
        chk({tag, ".busy"}, 8'(bus.busy),     8'(e.busy));
        chk({tag, ".to"},   8'(bus.timeout),  8'(e.to));
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;

        v[0]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 1, 1, 0};
        v[1]  = '{4'b0100, 4'b0000, 4'b0100, 2'd2, 0, 1, 1, 0};
        v[2]  = '{4'b0000, 4'b1111, 4'b0000, 2'd2, 0, 0, 1, 0};
        v[3]  = '{4'b0000, 4'b1111, 4'b0000, 2'd2, 0, 0, 0, 0};
        v[4]  = '{4'b1111, 4'b0000, 4'b1000, 2'd3, 0, 1, 1, 0};
        v[5]  = '{4'b1111, 4'b1000, 4'b1000, 2'd3, 1, 1, 1, 0};
        v[6]  = '{4'b1111, 4'b0111, 4'b1000, 2'd3, 0, 1, 1, 0};
        v[7]  = '{4'b1111, 4'b1111, 4'b1000, 2'd3, 1, 1, 1, 0};
        v[8]  = '{4'b1111, 4'b1111, 4'b0000, 2'd3, 0, 0, 1, 1};
        v[9]  = '{4'b1111, 4'b0001, 4'b0001, 2'd0, 1, 1, 1, 0};
        v[10] = '{4'b1111, 4'b1110, 4'b0001, 2'd0, 0, 1, 1, 0};
        v[11] = '{4'b1111, 4'b0001, 4'b0001, 2'd0, 1, 1, 1, 0};
        v[12] = '{4'b1111, 4'b0000, 4'b0001, 2'd0, 0, 1, 1, 0};
        v[13] = '{4'b1111, 4'b1111, 4'b0000, 2'd0, 0, 0, 1, 1};
        v[14] = '{4'b1111, 4'b0010, 4'b0010, 2'd1, 1, 1, 1, 0};
        v[15] = '{4'b1010, 4'b0000, 4'b0010, 2'd1, 0, 1, 1, 0};
        v[16] = '{4'b1000, 4'b0010, 4'b0000, 2'd1, 0, 0, 1, 0};
        v[17] = '{4'b1010, 4'b1000, 4'b1000, 2'd3, 1, 1, 1, 0};
        v[18] = '{4'b0010, 4'b1000, 4'b0000, 2'd3, 0, 0, 1, 0};
        v[19] = '{4'b0010, 4'b0000, 4'b0010, 2'd1, 0, 1, 1, 0};
        v[20] = '{4'b0010, 4'b0010, 4'b0010, 2'd1, 1, 1, 1, 0};
        v[21] = '{4'b0010, 4'b0100, 4'b0010, 2'd1, 0, 1, 1, 0};
        v[22] = '{4'b0010, 4'b0010, 4'b0010, 2'd1, 1, 1, 1, 0};
        v[23] = '{4'b0000, 4'b0010, 4'b0000, 2'd1, 0, 0, 1, 0};
        v[24] = '{4'b0000, 4'b0000, 4'b0000, 2'd1, 0, 0, 0, 0};

        rst     = 1'b1;
        bus.req = 4'b0000;
        bus.din = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.gnt",  8'(bus.gnt),      8'h00);
        chk("rst.sel",  8'(bus.sel),      8'h00);
        chk("rst.dout", 8'(bus.dout),     8'h00);
        chk("rst.vld",  8'(bus.dout_vld), 8'h00);
        chk("rst.busy", 8'(bus.busy),     8'h00);
        chk("rst.to",   8'(bus.timeout),  8'h00);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle.gnt",  8'(bus.gnt),  8'h00);
        chk("idle.busy", 8'(bus.busy), 8'h00);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            bus.req = v[i].req;
            bus.din = v[i].din;
            @(posedge clk);
            #1;
            chk_all($sformatf("v%0d", i), v[i]);
        end
        chk("h1.idle", 8'(bus1.busy), 8'h00);

        // Sole requester 0: period MAX_HOLD+1 here, period 2 at MAX_HOLD=1.
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            bus.req = 4'b0001;
            bus.din = 4'b0000;
            @(posedge clk);
            #1;
            chk($sformatf("solo%0d.g", k),
                8'(bus.gnt), (k % 5 != 0) ? 8'h01 : 8'h00);
            chk($sformatf("solo%0d.t", k),
                8'(bus.timeout), (k % 5 == 0) ? 8'h01 : 8'h00);
            chk($sformatf("h1_%0d.g", k),
                8'(bus1.gnt), (k % 2 == 1) ? 8'h01 : 8'h00);
            chk($sformatf("h1_%0d.t", k),
                8'(bus1.timeout), (k % 2 == 0) ? 8'h01 : 8'h00);
        end

        @(negedge clk);
        bus.req = 4'b0000;
        @(posedge clk);
        #1;
        chk("solo.idle", 8'(bus.busy), 8'h00);

        @(negedge clk);
        bus.req = 4'b0010;
        bus.din = 4'b0010;
        @(posedge clk);
        #1;
        chk("pre.gnt",  8'(bus.gnt),  8'h02);
        chk("pre.dout", 8'(bus.dout), 8'h01);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.gnt",  8'(bus.gnt),      8'h00);
        chk("arst.vld",  8'(bus.dout_vld), 8'h00);
        chk("arst.dout", 8'(bus.dout),     8'h00);
        chk("arst.busy", 8'(bus.busy),     8'h00);
        chk("arst.sel",  8'(bus.sel),      8'h00);

        @(negedge clk);
        rst     = 1'b0;
        bus.req = 4'b1111;
        @(posedge clk);
        #1;
        chk("post.gnt", 8'(bus.gnt), 8'h01);
        chk("post.sel", 8'(bus.sel), 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
